// File: rtl/buffer_pkg.sv
// Shared constants, state encoding and byte-field helpers for the nibble-pair buffer link.
package buffer_pkg;

  localparam int FRAME_BYTES = 16;
  localparam int BYTE_BITS   = 8;
  localparam int CNT_W       = 7;
  localparam int NIB_W       = 4;
  localparam int DATA_LSB    = 0;
  localparam int ADDR_LSB    = 4;
  localparam int TABLE_DEPTH = 1 << NIB_W;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BYTES * BYTE_BITS - 1);
  localparam logic [2:0]       BYTE_END = 3'(BYTE_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [NIB_W-1:0] get_addr(input logic [BYTE_BITS-1:0] b);
    return b[ADDR_LSB +: NIB_W];
  endfunction

  function automatic logic [NIB_W-1:0] get_data(input logic [BYTE_BITS-1:0] b);
    return b[DATA_LSB +: NIB_W];
  endfunction

endpackage

// File: rtl/nib_table.sv
// 16x4 register file with per-entry valid bitmap, bulk bitmap clear and a
// registered read port that returns pre-write contents on a same-edge collision.
module nib_table
  import buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [NIB_W-1:0] i_wr_addr,
  input  logic [NIB_W-1:0] i_wr_data,
  input  logic [NIB_W-1:0] i_rd_addr,
  output logic [NIB_W-1:0] o_rd_data,
  output logic             o_rd_hit
);

  logic [NIB_W-1:0]       r_mem [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0] r_valid;

  // NOTE: the table is small and downstream logic reads it straight after reset,
  // so the storage array is reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_DEPTH; i++) r_mem[i] <= '0;
      r_valid   <= '0;
      o_rd_data <= '0;
      o_rd_hit  <= 1'b0;
    end else begin
      o_rd_data <= r_mem[i_rd_addr];
      o_rd_hit  <= r_valid[i_rd_addr];
      if (i_clr) r_valid <= '0;
      // A write on the clear edge still marks its entry valid.
      if (i_wr_en) begin
        r_mem[i_wr_addr]   <= i_wr_data;
        r_valid[i_wr_addr] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/debuffer.sv
// Serial receiver: reassembles 16 LSB-first {addr, data} bytes per frame, pulses
// each completed byte and stores it in an address-indexed nibble table.
module debuffer
  import buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_in,
  input  logic             data_in,
  input  logic [NIB_W-1:0] rd_addr,
  output logic [NIB_W-1:0] addr_out,
  output logic [NIB_W-1:0] data_out,
  output logic             byte_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic [NIB_W-1:0] rd_data,
  output logic             rd_hit
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [BYTE_BITS-1:0]   r_shreg;
  logic [BYTE_BITS-1:0]   w_byte;
  logic                   w_start;
  logic                   w_sample;
  logic                   w_byte_done;
  logic                   w_last;
  logic                   w_abort;

  assign w_byte = {data_in, r_shreg[BYTE_BITS-1:1]};

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_byte_done  = 1'b0;
    w_last       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ena_in) begin
          w_start      = 1'b1;
          w_sample     = 1'b1;
          w_next_state = RECV;
        end
      end
      RECV: begin
        if (!ena_in) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_sample    = 1'b1;
          w_byte_done = (r_bit_cnt[2:0] == BYTE_END);
          if (r_bit_cnt == LAST_BIT) begin
            w_last       = 1'b1;
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        // The transmitter keeps clocking bits out after the frame; wait for its enable to drop.
        if (!ena_in) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= w_byte_done;
      frame_done <= w_last;
      frame_err  <= w_abort;
      if (w_sample) r_shreg <= w_byte;
      if (w_start)       r_bit_cnt <= CNT_W'(1);
      else if (w_sample) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_byte_done) begin
        addr_out <= get_addr(w_byte);
        data_out <= get_data(w_byte);
      end
    end
  end

  // Table write trails byte_valid by one edge, using the registered nibbles.
  nib_table u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_start),
    .i_wr_en   (byte_valid),
    .i_wr_addr (addr_out),
    .i_wr_data (data_out),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_rd_hit  (rd_hit)
  );

endmodule

// File: tb/tb_debuffer.sv
// Self-checking bench for debuffer: random frames against a frame-level model of
// the byte stream and the address-indexed table.
module tb_debuffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena_in;
  logic       data_in;
  logic [3:0] rd_addr;
  logic [3:0] addr_out;
  logic [3:0] data_out;
  logic       byte_valid;
  logic       frame_done;
  logic       frame_err;
  logic [3:0] rd_data;
  logic       rd_hit;

  debuffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_in     (ena_in),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .byte_valid (byte_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .rd_data    (rd_data),
    .rd_hit     (rd_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  fr [16];
  logic [3:0]  m_mem [16];
  logic [15:0] m_valid;
  logic [3:0]  last_a, last_d;
  logic        pend;
  logic [3:0]  pend_a, pend_d;
  logic [3:0]  tb_rd_addr;
  logic        rand_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_valid = '0;
    last_a  = '0;
    last_d  = '0;
    pend    = 1'b0;
    pend_a  = '0;
    pend_d  = '0;
  endtask

  // One clock: drive at negedge, model the edge, check #1 after the posedge.
  task automatic step(input logic e, input logic d, input logic start, input logic bv,
                      input logic fd, input logic fe, input logic [7:0] b);
    logic [3:0] exp_rd;
    logic       exp_hit;
    @(negedge clk);
    if (rand_rd) tb_rd_addr = 4'($urandom_range(0, 15));
    ena_in  = e;
    data_in = d;
    rd_addr = tb_rd_addr;
    @(posedge clk);
    exp_rd  = m_mem[tb_rd_addr];
    exp_hit = m_valid[tb_rd_addr];
    if (start) m_valid = '0;
    if (pend) begin
      m_mem[pend_a]   = pend_d;
      m_valid[pend_a] = 1'b1;
    end
    pend = bv;
    if (bv) begin
      pend_a = b[7:4];
      pend_d = b[3:0];
      last_a = b[7:4];
      last_d = b[3:0];
    end
    #1;
    check("byte_valid", 32'(byte_valid), 32'(bv));
    check("frame_done", 32'(frame_done), 32'(fd));
    check("frame_err",  32'(frame_err),  32'(fe));
    check("addr_out",   32'(addr_out),   32'(last_a));
    check("data_out",   32'(data_out),   32'(last_d));
    check("rd_data",    32'(rd_data),    32'(exp_rd));
    check("rd_hit",     32'(rd_hit),     32'(exp_hit));
  endtask

  // Send the first nbits of fr, then extra high cycles, then drop enable for idle cycles.
  task automatic run_frame(input int nbits, input int extra_high, input int idle);
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] cur;
      cur = fr[i / 8];
      step(1'b1, cur[i % 8], i == 0, (i % 8) == 7, i == 127, 1'b0, cur);
    end
    for (int i = 0; i < extra_high; i++)
      step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < idle; i++)
      step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, (i == 0) && (nbits < 128), 8'h00);
  endtask

  task automatic read_all();
    logic save;
    save    = rand_rd;
    rand_rd = 1'b0;
    for (int a = 0; a < 16; a++) begin
      tb_rd_addr = 4'(a);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    rand_rd = save;
  endtask

  task automatic random_fr();
    for (int k = 0; k < 16; k++) fr[k] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_err"},  32'(frame_err),  32'd0);
    check({tag, "_addr_out"},   32'(addr_out),   32'd0);
    check({tag, "_data_out"},   32'(data_out),   32'd0);
    check({tag, "_rd_data"},    32'(rd_data),    32'd0);
    check({tag, "_rd_hit"},     32'(rd_hit),     32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    ena_in     = 1'b0;
    data_in    = 1'b0;
    rd_addr    = '0;
    tb_rd_addr = '0;
    rand_rd    = 1'b1;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Full frame {k, 15-k}
    for (int k = 0; k < 16; k++) fr[k] = {4'(k), 4'(15 - k)};
    run_frame(128, 3, 1);
    read_all();
    rand_rd    = 1'b0;
    tb_rd_addr = 4'd5;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rd5_data", 32'(rd_data), 32'd10);
    check("rd5_hit",  32'(rd_hit),  32'd1);

    // Duplicate address, read port parked on the colliding entry
    fr[0] = 8'h3A;
    fr[1] = 8'h3C;
    for (int k = 2; k < 16; k++) fr[k] = {(k == 3) ? 4'd2 : 4'(k), 4'($urandom)};
    tb_rd_addr = 4'd3;
    run_frame(128, 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("dup_rd3_data", 32'(rd_data), 32'hC);
    rand_rd = 1'b1;

    // Abort after 20 bits
    for (int k = 0; k < 16; k++) fr[k] = {4'(15 - k), 4'($urandom)};
    run_frame(20, 0, 2);
    read_all();

    // Post-frame streaming, then one low cycle and a new (aborted) frame
    random_fr();
    run_frame(128, 200, 1);
    for (int k = 0; k < 16; k++) fr[k] = {4'(k + 6), 4'($urandom)};
    run_frame(16, 0, 1);
    read_all();

    // Random frames of random length and trailing behaviour
    for (int f = 0; f < 6; f++) begin
      random_fr();
      if (f % 2 == 0) run_frame(128, $urandom_range(0, 10), $urandom_range(1, 3));
      else            run_frame($urandom_range(1, 127), 0, $urandom_range(1, 3));
      read_all();
    end

    // Reset in the middle of a frame: no frame_err, table wiped
    random_fr();
    run_frame(128, 0, 1);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] cur;
      cur = fr[i / 8];
      step(1'b1, cur[i % 8], i == 0, (i % 8) == 7, 1'b0, 1'b0, cur);
    end
    @(negedge clk);
    rst_n  = 1'b0;
    ena_in = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    read_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
